// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiplier stream driver.
package mvm_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    STREAM,
    WAIT_DONE,
    CAPTURE,
    DRAIN
  } drv_state_t;

  localparam int MAT_SCALE_DEF = 3;
  localparam int IW_DEF        = 8;
  localparam int OW_DEF        = 16;
  localparam int FRAME_IN      = MAT_SCALE_DEF * MAT_SCALE_DEF + MAT_SCALE_DEF;
  localparam int FRAME_OUT     = MAT_SCALE_DEF;

  typedef logic signed [IW_DEF-1:0] operand_t;
  typedef logic signed [OW_DEF-1:0] result_t;

  function automatic int frame_in(input int n);
    return n * n + n;
  endfunction

  // Counter width able to hold 0..top; never narrower than one bit.
  function automatic int cnt_w(input int top);
    return (top < 1) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..TOP with synchronous clear; wraps to zero after TOP.
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int TOP   = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             at_top
);

  assign at_top = (cnt == WIDTH'(TOP));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_top ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mvm_stream_driver.sv
// Host-side driver: buffers an operand frame, streams it to the multiplier after a
// start pulse, captures the result vector and hands it out on a valid/ready port.
module mvm_stream_driver #(
  parameter int MAT_SCALE    = 3,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic signed [INPUT_WIDTH-1:0]  ld_data,
  output logic                           busy,
  output logic                           mvm_start,
  output logic signed [INPUT_WIDTH-1:0]  mvm_data_in,
  input  logic                           mvm_done,
  input  logic signed [OUTPUT_WIDTH-1:0] mvm_data_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [OUTPUT_WIDTH-1:0] res_data,
  output logic                           res_last,
  output logic                           timeout_err
);
  import mvm_pkg::*;

  localparam int N_IN  = frame_in(MAT_SCALE);
  localparam int N_OUT = MAT_SCALE;
  localparam int IDX_W = cnt_w(N_IN - 1);
  localparam int RES_W = cnt_w(N_OUT - 1);
  localparam int TMR_W = cnt_w(DONE_TIMEOUT - 1);

  typedef logic signed [INPUT_WIDTH-1:0]  opnd_t;
  typedef logic signed [OUTPUT_WIDTH-1:0] rslt_t;

  drv_state_t state;

  opnd_t abuf [N_IN];
  rslt_t ybuf [N_OUT];

  logic [IDX_W-1:0] idx;
  logic             idx_top;
  logic [RES_W-1:0] res_cnt;
  logic [RES_W-1:0] res_nxt;
  logic             res_top;
  logic [TMR_W-1:0] tmr_cnt_unused;
  logic             tmr_top;

  logic ld_acc;
  logic idx_en;
  logic res_en;
  logic cap_en;
  logic tmr_clr;

  assign ld_acc  = (state == LOAD) && ld_valid && ld_ready;
  assign idx_en  = ld_acc || (state == START) || (state == STREAM);
  assign cap_en  = ((state == WAIT_DONE) && mvm_done) || (state == CAPTURE);
  assign res_en  = cap_en || ((state == DRAIN) && res_valid && res_ready);
  assign tmr_clr = reset || (state != WAIT_DONE);
  assign res_nxt = res_cnt + 1'b1;

  // One index serves both the load write pointer and the stream read pointer:
  // it wraps to zero on the last load, which is exactly where streaming starts.
  mod_counter #(.WIDTH(IDX_W), .TOP(N_IN - 1)) u_idx_cnt (
    .clk    (clk),
    .clr    (reset),
    .en     (idx_en),
    .cnt    (idx),
    .at_top (idx_top)
  );

  mod_counter #(.WIDTH(RES_W), .TOP(N_OUT - 1)) u_res_cnt (
    .clk    (clk),
    .clr    (reset),
    .en     (res_en),
    .cnt    (res_cnt),
    .at_top (res_top)
  );

  mod_counter #(.WIDTH(TMR_W), .TOP(DONE_TIMEOUT - 1)) u_tmr_cnt (
    .clk    (clk),
    .clr    (tmr_clr),
    .en     (state == WAIT_DONE),
    .cnt    (tmr_cnt_unused),
    .at_top (tmr_top)
  );

  // Operand and result storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      abuf[idx] <= ld_data;
    end
    if (cap_en) begin
      ybuf[res_cnt] <= mvm_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      ld_ready    <= 1'b1;
      busy        <= 1'b0;
      mvm_start   <= 1'b0;
      mvm_data_in <= '0;
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      mvm_start <= 1'b0;
      if (mvm_done && (state != WAIT_DONE)) begin
        timeout_err <= 1'b1;
      end
      case (state)
        LOAD: begin
          if (ld_acc) begin
            busy <= 1'b1;
            if (idx_top) begin
              ld_ready  <= 1'b0;
              mvm_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          mvm_data_in <= abuf[idx];
          state       <= STREAM;
        end
        STREAM: begin
          mvm_data_in <= abuf[idx];
          if (idx_top) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          mvm_data_in <= '0;
          if (mvm_done) begin
            if (N_OUT == 1) begin
              state     <= DRAIN;
              res_valid <= 1'b1;
              res_data  <= mvm_data_out;
              res_last  <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end else if (tmr_top) begin
            timeout_err <= 1'b1;
            ld_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= LOAD;
          end
        end
        CAPTURE: begin
          if (res_top) begin
            state     <= DRAIN;
            res_valid <= 1'b1;
            res_data  <= ybuf[0];
            res_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (res_valid && res_ready) begin
            if (res_top) begin
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              busy      <= 1'b0;
              ld_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              res_data <= ybuf[res_nxt];
              res_last <= (res_nxt == RES_W'(N_OUT - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
